// File: rtl/handshake_arb_pkg.sv
// Shared constants and helpers for the round-robin handshake arbiter.
package handshake_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BURST  = 4;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import handshake_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int              cand;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    any_valid = 1'b0;
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    cidx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = IDX_W'(cand);
      if (!any_valid && valid[cidx]) begin
        any_valid   = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding a single-entry registered output stage.
// Optional burst lock is compiled in with `define HANDSHAKE_ARB_BURST_LOCK_EN.
module handshake_rr_arbiter
  import handshake_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 in_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]                 in_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [IDX_W-1:0]                   out_src,
  input  logic                               out_ready
);

  if (NUM_REQ < 1 || MAX_BURST < 1) begin : g_bad_cfg
    $error("handshake_rr_arbiter: NUM_REQ and MAX_BURST must be >= 1");
  end

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) >= NUM_REQ - 1) return '0;
    return IDX_W'(int'(i) + 1);
  endfunction

  logic [IDX_W-1:0]   ptr;
  logic               rr_any;
  logic [NUM_REQ-1:0] rr_grant;
  logic [IDX_W-1:0]   rr_idx;

  logic               sel_any;
  logic [NUM_REQ-1:0] sel_grant;
  logic [IDX_W-1:0]   sel_idx;

  logic load_en;
  logic load;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid     (in_valid),
    .ptr       (ptr),
    .any_valid (rr_any),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

`ifdef HANDSHAKE_ARB_BURST_LOCK_EN
  localparam int CNT_W = idx_w(MAX_BURST + 1);

  logic             lock_vld;
  logic [IDX_W-1:0] lock_idx;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] beats;
  logic             lock_hit;

  // A held lock overrides the rotation only while its owner keeps valid high.
  assign lock_hit = lock_vld && in_valid[lock_idx];
  assign sel_any  = lock_hit || rr_any;
  assign sel_idx  = lock_hit ? lock_idx : rr_idx;
  assign beats    = CNT_W'(lock_hit ? int'(burst_cnt) + 1 : 1);

  always_comb begin
    sel_grant = rr_grant;
    if (lock_hit) begin
      sel_grant           = '0;
      sel_grant[lock_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
      burst_cnt <= '0;
    end else if (load) begin
      if (int'(beats) >= MAX_BURST) begin
        lock_vld  <= 1'b0;
        burst_cnt <= '0;
      end else begin
        lock_vld  <= 1'b1;
        lock_idx  <= sel_idx;
        burst_cnt <= beats;
      end
    end else if (load_en && lock_vld && !in_valid[lock_idx]) begin
      lock_vld  <= 1'b0;
      burst_cnt <= '0;
    end
  end
`else
  assign sel_any   = rr_any;
  assign sel_grant = rr_grant;
  assign sel_idx   = rr_idx;
`endif

  assign load_en  = !out_valid || out_ready;
  assign load     = load_en && sel_any;
  // Gate with rst_n so no requester sees ready while the block is held in reset.
  assign in_ready = sel_grant & {NUM_REQ{load_en && rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload register is reset as well, so out_data reads 0 after reset rather than X.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
      out_valid <= 1'b1;
      out_data  <= in_data[sel_idx];
      out_src   <= sel_idx;
      ptr       <= wrap_inc(sel_idx);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench: a 4-requester and a 3-requester arbiter against a
// behavioural round-robin model, with directed steps and a randomized phase.
module tb_handshake_rr_arbiter;

`ifdef HANDSHAKE_ARB_BURST_LOCK_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int MB4 = 4;
  localparam int MB3 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]       v4;
  logic [3:0][31:0] d4;
  logic [3:0]       rdy4;
  logic             ov4;
  logic [31:0]      od4;
  logic [1:0]       os4;
  logic             ordy4;

  logic [2:0]       v3;
  logic [2:0][31:0] d3;
  logic [2:0]       rdy3;
  logic             ov3;
  logic [31:0]      od3;
  logic [1:0]       os3;
  logic             ordy3;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          ptr;
    int          lock;
    int          cnt;
    bit          ov;
    logic [31:0] od;
    int          os;
  } mstate_t;

  mstate_t m4, m3;
  int      xfer3 [4];
  bit      seen02;
  int      exp1 [5];
  int      exp5 [5];
  logic [31:0] held;

  always #5 clk = ~clk;

  handshake_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(MB4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_src(os4), .out_ready(ordy4)
  );

  handshake_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .MAX_BURST(MB3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(ordy3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t s;
    s.ptr = 0; s.lock = -1; s.cnt = 0; s.ov = 1'b0; s.od = '0; s.os = 0;
    return s;
  endfunction

  // Winner: the locked owner if still valid, else first valid from ptr with wrap.
  function automatic int pick(mstate_t s, logic [3:0] v, int n);
    if (BURST && s.lock >= 0 && v[s.lock]) return s.lock;
    for (int k = 0; k < n; k++)
      if (v[(s.ptr + k) % n]) return (s.ptr + k) % n;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(mstate_t s, logic [3:0] v, logic ordy, int n);
    int g = pick(s, v, n);
    logic [3:0] one = 4'b0001;
    if ((!s.ov || ordy) && g >= 0) return one << g;
    return 4'b0000;
  endfunction

  function automatic mstate_t advance(mstate_t s, logic [3:0] v, logic [3:0][31:0] d,
                                      logic ordy, int n, int maxb);
    mstate_t r = s;
    bit le = !s.ov || ordy;
    int g  = pick(s, v, n);
    int nb;
    if (le && g >= 0) begin
      r.ov = 1'b1; r.od = d[g]; r.os = g; r.ptr = (g + 1) % n;
      if (BURST) begin
        nb = (s.lock == g) ? s.cnt + 1 : 1;
        if (nb >= maxb) begin r.lock = -1; r.cnt = 0; end
        else begin r.lock = g; r.cnt = nb; end
      end
    end else begin
      if (ordy) r.ov = 1'b0;
      if (BURST && le && s.lock >= 0 && !v[s.lock]) begin r.lock = -1; r.cnt = 0; end
    end
    return r;
  endfunction

  // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    check("rdy4", rdy4, exp_rdy(m4, v4, ordy4, 4));
    check("ov4",  ov4,  m4.ov);
    check("od4",  od4,  m4.od);
    check("os4",  os4,  m4.os);
    check("rdy3", {1'b0, rdy3}, exp_rdy(m3, {1'b0, v3}, ordy3, 3));
    check("ov3",  ov3,  m3.ov);
    check("od3",  od3,  m3.od);
    check("os3",  os3,  m3.os);
    seen02 |= |(rdy4 & 4'b0101);
    if (ov3 && ordy3) xfer3[os3]++;
    m4 = advance(m4, v4, d4, ordy4, 4, MB4);
    m3 = advance(m3, {1'b0, v3}, {32'h0, d3}, ordy3, 3, MB3);
    @(posedge clk);
    #1;
  endtask

  task automatic rand4();
    for (int k = 0; k < 4; k++) d4[k] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HANDSHAKE_ARB_BURST_LOCK_EN
    exp1 = '{0, 0, 0, 0, 1};
    exp5 = '{0, 0, 0, 1, 1};
`else
    exp1 = '{0, 1, 2, 3, 0};
    exp5 = '{1, 2, 3, 0, 1};
`endif
    v4 = '1; d4 = '0; ordy4 = 1'b1;
    v3 = '0; d3 = '0; ordy3 = 1'b1;
    m4 = reset_state(); m3 = reset_state();
    seen02 = 1'b0;
    foreach (xfer3[k]) xfer3[k] = 0;

    // Reset with every requester valid.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov4", ov4, 0);
    check("rst_rdy4", rdy4, 0);
    check("rst_od4", od4, 0);
    check("rst_os4", os4, 0);
    check("rst_ov3", ov3, 0);
    check("rst_rdy3", rdy3, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      rand4();
      step();
      check($sformatf("t1_src%0d", i), os4, exp1[i]);
    end

    // Only requesters 1 and 3 valid.
    v4 = 4'b1010; seen02 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand4();
      step();
`ifndef HANDSHAKE_ARB_BURST_LOCK_EN
      check($sformatf("t2_src%0d", i), os4, (i % 2 == 0) ? 1 : 3);
`endif
    end
    check("t2_rdy02_never", seen02, 0);

    // Five-cycle stall, then reopen without a bubble.
    v4 = '1; ordy4 = 1'b0;
    held = m4.od;
    for (int i = 0; i < 5; i++) begin
      rand4();
      step();
    end
    check("t3_held_valid", ov4, 1);
    check("t3_held_data", od4, held);
    ordy4 = 1'b1;
    rand4();
    step();
    check("t3_nobubble", ov4, 1);

    // Three requesters, data = src*0x100 + seq.
    foreach (xfer3[k]) xfer3[k] = 0;
    v3 = '1; ordy3 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 3; k++) d3[k] = 32'(k * 256 + i);
      step();
      if (i < 6) check($sformatf("t4_src%0d", i), os3, i % 3);
    end
    v3 = '0;
    step();
    for (int k = 0; k < 3; k++) check($sformatf("t4_count%0d", k), xfer3[k], 4);

    // Randomized traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      v4 = 4'($urandom); ordy4 = ($urandom_range(0, 3) != 0);
      v3 = 3'($urandom); ordy3 = ($urandom_range(0, 3) != 0);
      rand4();
      for (int k = 0; k < 3; k++) d3[k] = $urandom;
      step();
    end

    // Asynchronous reset while a beat is stalled.
    v4 = '1; ordy4 = 1'b0; v3 = '1; ordy3 = 1'b0;
    rand4();
    step();
    step();
    check("t6_pre_ov4", ov4, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_ov4", ov4, 0);
    check("t6_async_rdy4", rdy4, 0);
    check("t6_async_ov3", ov3, 0);
    check("t6_async_od4", od4, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m4 = reset_state(); m3 = reset_state();
    ordy4 = 1'b1; ordy3 = 1'b1; v3 = '0;
    rand4();
    step();
    check("t6_restart_src", os4, 0);

    // Continued rotation after reset; with burst lock, requester 1 then drops early.
    for (int i = 0; i < 5; i++) begin
      rand4();
      step();
      check($sformatf("t5_src%0d", i), os4, exp5[i]);
    end
`ifdef HANDSHAKE_ARB_BURST_LOCK_EN
    v4 = 4'b1101;
    rand4();
    step();
    check("t5_release_src", os4, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
